// File: rtl/tag_pkg.sv
// tag_pkg: shared request opcodes and flush FSM states for the tag array
package tag_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_FILL   = 2'b01,
        OP_INVAL  = 2'b10
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/tag_array_plru_if.sv
// tag_array_plru_if: request/flush/response bundle between cache controller (master) and tag array (slave)
interface tag_array_plru_if #(
    parameter int TAG_WIDTH   = 7,
    parameter int INDEX_WIDTH = 6,
    parameter int WAY_WIDTH   = 3
);
    logic                             req_valid;
    logic                             req_ready;
    logic [1:0]                       req_op;
    logic [TAG_WIDTH+INDEX_WIDTH-1:0] req_addr;
    logic                             req_wr;
    logic                             flush_start;
    logic                             flush_busy;
    logic                             rsp_valid;
    logic                             rsp_hit;
    logic [WAY_WIDTH-1:0]             rsp_way;
    logic                             rsp_victim_valid;
    logic                             rsp_victim_dirty;
    logic [TAG_WIDTH-1:0]             rsp_victim_tag;

    modport master (
        output req_valid, req_op, req_addr, req_wr, flush_start,
        input  req_ready, flush_busy, rsp_valid, rsp_hit, rsp_way,
               rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wr, flush_start,
        output req_ready, flush_busy, rsp_valid, rsp_hit, rsp_way,
               rsp_victim_valid, rsp_victim_dirty, rsp_victim_tag
    );
endinterface

// File: rtl/tag_repl.sv
// tag_repl: per-set replacement state; TAG_PLRU_EN selects tree pseudo-LRU, otherwise a per-set FIFO pointer
module tag_repl #(
    parameter int INDEX_WIDTH = 6,
    parameter int WAY_WIDTH   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] idx,
    output logic [WAY_WIDTH-1:0]   victim,
    input  logic                   touch,
    input  logic [WAY_WIDTH-1:0]   touch_way,
    input  logic                   evict,
    input  logic                   clr,
    input  logic [INDEX_WIDTH-1:0] clr_idx
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int WAYS = 1 << WAY_WIDTH;

`ifdef TAG_PLRU_EN
    // heap-ordered tree: node n has children 2n and 2n+1; bit 0 sends the victim walk left
    logic [WAYS-1:1] tree_q [SETS];
    logic [WAYS-1:1] tree_d;
    logic [WAY_WIDTH:0] node_v;
    logic [WAY_WIDTH:0] node_u;
    logic [WAY_WIDTH-1:0] way_u;
    logic unused_evict;

    assign unused_evict = evict;

    // follow the tree bits to the victim leaf, and build the tree with the touched leaf pointed away from
    always_comb begin
        tree_d = tree_q[idx];
        node_v = {{WAY_WIDTH{1'b0}}, 1'b1};
        node_u = {{WAY_WIDTH{1'b0}}, 1'b1};
        way_u  = touch_way;
        for (int l = 0; l < WAY_WIDTH; l++) begin
            node_v = {node_v[WAY_WIDTH-1:0], tree_q[idx][node_v[WAY_WIDTH-1:0]]};
            tree_d[node_u[WAY_WIDTH-1:0]] = ~way_u[WAY_WIDTH-1];
            node_u = {node_u[WAY_WIDTH-1:0], way_u[WAY_WIDTH-1]};
            way_u  = way_u << 1;
        end
        victim = node_v[WAY_WIDTH-1:0];
    end

    // tree storage: cleared on reset or by the flush walker, rewritten on every access
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
        end else begin
            if (clr) tree_q[clr_idx] <= '0;
            if (touch) tree_q[idx] <= tree_d;
        end
    end
`else
    logic [WAY_WIDTH-1:0] ptr_q [SETS];
    logic unused_touch;

    assign unused_touch = ^{touch, touch_way};
    assign victim = ptr_q[idx];

    // round-robin pointer advances only when a valid line was displaced
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
        end else begin
            if (clr) ptr_q[clr_idx] <= '0;
            if (evict) ptr_q[idx] <= ptr_q[idx] + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/tag_array_plru.sv
// tag_array_plru: set-associative tag/valid/dirty array with 1-cycle responses, victim reporting and flush (TAG_PLRU_EN selects PLRU replacement)
module tag_array_plru
    import tag_pkg::*;
#(
    parameter int TAG_WIDTH   = 7,
    parameter int INDEX_WIDTH = 6,
    parameter int WAY_WIDTH   = 3
) (
    input logic             clk,
    input logic             reset,
    tag_array_plru_if.slave bus
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int WAYS = 1 << WAY_WIDTH;

    state_e                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;

    logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   acc, is_fill, is_inval;
    logic                   hit, has_inv;
    logic [WAY_WIDTH-1:0]   hit_way, inv_way, repl_way, victim, way;
    logic                   vv, vd, hd;
    logic [TAG_WIDTH-1:0]   vt;
    logic                   rv_valid, rv_dirty;
    logic [TAG_WIDTH-1:0]   rv_tag;

    assign idx      = bus.req_addr[INDEX_WIDTH-1:0];
    assign tag      = bus.req_addr[TAG_WIDTH+INDEX_WIDTH-1:INDEX_WIDTH];
    assign acc      = bus.req_valid && bus.req_ready;
    assign is_fill  = bus.req_op == OP_FILL;
    assign is_inval = bus.req_op == OP_INVAL;

    // tag compare across the set plus lowest-index invalid way (descending scan so the lowest wins)
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_WIDTH'(w);
            end
            if (!valid_q[idx][w]) begin
                has_inv = 1'b1;
                inv_way = WAY_WIDTH'(w);
            end
        end
    end

    assign victim = has_inv ? inv_way : repl_way;
    assign way    = hit ? hit_way : victim;
    assign vv     = valid_q[idx][victim];
    assign vd     = dirty_q[idx][victim];
    assign vt     = tag_q[idx][victim];
    assign hd     = dirty_q[idx][hit_way];

    // INVAL reports the line it removes; LOOKUP/FILL report the victim only on a miss
    assign rv_valid = is_inval ? hit : !hit && vv;
    assign rv_dirty = is_inval ? hit && hd : !hit && vv && vd;
    assign rv_tag   = rv_valid ? (is_inval ? tag : vt) : '0;

    tag_repl #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .WAY_WIDTH  (WAY_WIDTH)
    ) u_repl (
        .clk      (clk),
        .reset    (reset),
        .idx      (idx),
        .victim   (repl_way),
        .touch    (acc && (is_fill || (!is_inval && hit))),
        .touch_way(way),
        .evict    (acc && is_fill && !hit && !has_inv),
        .clr      (state_q == ST_FLUSH),
        .clr_idx  (cnt_q)
    );

    // flush sequencer next state: one set per cycle, back to IDLE after the last set
    always_comb begin
        state_d = state_q == ST_IDLE ? (bus.flush_start ? ST_FLUSH : ST_IDLE)
                                     : (&cnt_q ? ST_IDLE : ST_FLUSH);
        cnt_d   = state_q == ST_FLUSH ? cnt_q + 1'b1 : '0;
    end

    // FSM state with ready/busy registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            bus.req_ready  <= 1'b0;
            bus.flush_busy <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus.req_ready  <= state_d == ST_IDLE;
            bus.flush_busy <= state_d == ST_FLUSH;
        end
    end

    // valid/dirty bits: flush clears one set per cycle, otherwise accepted requests commit here
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (state_q == ST_FLUSH) begin
            valid_q[cnt_q] <= '0;
            dirty_q[cnt_q] <= '0;
        end else if (acc) begin
            if (is_fill) begin
                valid_q[idx][way] <= 1'b1;
                dirty_q[idx][way] <= bus.req_wr;
            end else if (is_inval && hit) begin
                valid_q[idx][hit_way] <= 1'b0;
                dirty_q[idx][hit_way] <= 1'b0;
            end else if (!is_inval && hit && bus.req_wr) begin
                dirty_q[idx][hit_way] <= 1'b1;
            end
        end
    end

    // tag storage needs no reset: a tag is only ever read behind its valid bit
    always_ff @(posedge clk) begin
        if (acc && is_fill) tag_q[idx][way] <= tag;
    end

    // registered response; fields hold between accepted requests
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid        <= 1'b0;
            bus.rsp_hit          <= 1'b0;
            bus.rsp_way          <= '0;
            bus.rsp_victim_valid <= 1'b0;
            bus.rsp_victim_dirty <= 1'b0;
            bus.rsp_victim_tag   <= '0;
        end else begin
            bus.rsp_valid <= acc;
            if (acc) begin
                bus.rsp_hit          <= hit;
                bus.rsp_way          <= way;
                bus.rsp_victim_valid <= rv_valid;
                bus.rsp_victim_dirty <= rv_dirty;
                bus.rsp_victim_tag   <= rv_tag;
            end
        end
    end

endmodule

// File: tb/tb_tag_array_plru.sv
// tb_tag_array_plru: directed self-checking bench for tag_array_plru (default FIFO replacement build)
module tb_tag_array_plru;
    import tag_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tag_array_plru_if #(.TAG_WIDTH(7), .INDEX_WIDTH(6), .WAY_WIDTH(3)) bus ();

    tag_array_plru #(.TAG_WIDTH(7), .INDEX_WIDTH(6), .WAY_WIDTH(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [13:0] obs;
    assign obs = {bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_victim_valid,
                  bus.rsp_victim_dirty, bus.rsp_victim_tag};

    typedef struct packed {
        logic [1:0]  op;
        logic [6:0]  t;
        logic [5:0]  i;
        logic        wr;
        logic [13:0] exp;
    } vec_t;

    function automatic logic [13:0] rsp(input logic h, input logic [2:0] w, input logic vv,
                                        input logic vd, input logic [6:0] vt);
        return {1'b1, h, w, vv, vd, vt};
    endfunction

    task automatic send(input logic [1:0] op, input logic [6:0] t, input logic [5:0] i, input logic wr);
        @(negedge clk);
        bus.req_op = op;
        bus.req_addr = {t, i};
        bus.req_wr = wr;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.flush_busy, bus.rsp_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=000", {bus.req_ready, bus.flush_busy, bus.rsp_valid});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.flush_busy, obs} !== {2'b10, 14'h0}) begin
            bad++;
            $display("FAIL reset_release got=%h exp=%h", {bus.req_ready, bus.flush_busy, obs}, {2'b10, 14'h0});
        end
    endtask

    task automatic test_lookup_empty;
        send(OP_LOOKUP, 7'h01, 6'h01, 1'b0);
        total++;
        if (obs !== rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)) begin
            bad++;
            $display("FAIL lookup_empty got=%h exp=%h", obs, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00));
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rsp_single_pulse got=%b exp=0", bus.rsp_valid);
        end
    endtask

    task automatic test_fill_set;
        for (int k = 0; k < 8; k++) begin
            send(OP_FILL, 7'h10 + 7'(k), 6'd5, k == 2);
            total++;
            if (obs !== rsp(1'b0, 3'(k), 1'b0, 1'b0, 7'h00)) begin
                bad++;
                $display("FAIL fill_way[%0d] got=%h exp=%h", k, obs, rsp(1'b0, 3'(k), 1'b0, 1'b0, 7'h00));
            end
        end
        send(OP_LOOKUP, 7'h12, 6'd5, 1'b0);
        total++;
        if (obs !== rsp(1'b1, 3'd2, 1'b0, 1'b0, 7'h00)) begin
            bad++;
            $display("FAIL lookup_hit got=%h exp=%h", obs, rsp(1'b1, 3'd2, 1'b0, 1'b0, 7'h00));
        end
    endtask

    task automatic test_evict;
        vec_t v [8];
        v = '{
            '{OP_FILL,   7'h20, 6'd5, 1'b0, rsp(1'b0, 3'd0, 1'b1, 1'b0, 7'h10)},
            '{OP_FILL,   7'h21, 6'd5, 1'b0, rsp(1'b0, 3'd1, 1'b1, 1'b0, 7'h11)},
            '{OP_FILL,   7'h22, 6'd5, 1'b0, rsp(1'b0, 3'd2, 1'b1, 1'b1, 7'h12)},
            '{OP_LOOKUP, 7'h30, 6'd5, 1'b0, rsp(1'b0, 3'd3, 1'b1, 1'b0, 7'h13)},
            '{OP_FILL,   7'h20, 6'd5, 1'b1, rsp(1'b1, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_INVAL,  7'h20, 6'd5, 1'b0, rsp(1'b1, 3'd0, 1'b1, 1'b1, 7'h20)},
            '{OP_FILL,   7'h31, 6'd5, 1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_FILL,   7'h32, 6'd5, 1'b0, rsp(1'b0, 3'd3, 1'b1, 1'b0, 7'h13)}
        };
        for (int k = 0; k < 8; k++) begin
            send(v[k].op, v[k].t, v[k].i, v[k].wr);
            total++;
            if (obs !== v[k].exp) begin
                bad++;
                $display("FAIL evict[%0d] got=%h exp=%h", k, obs, v[k].exp);
            end
        end
    endtask

    task automatic test_dirty_inval;
        vec_t v [8];
        v = '{
            '{OP_FILL,   7'h33, 6'd9, 1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_LOOKUP, 7'h33, 6'd9, 1'b1, rsp(1'b1, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_INVAL,  7'h33, 6'd9, 1'b0, rsp(1'b1, 3'd0, 1'b1, 1'b1, 7'h33)},
            '{OP_LOOKUP, 7'h33, 6'd9, 1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_INVAL,  7'h33, 6'd9, 1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_FILL,   7'h34, 6'd9, 1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{2'b11,     7'h34, 6'd9, 1'b1, rsp(1'b1, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_INVAL,  7'h34, 6'd9, 1'b0, rsp(1'b1, 3'd0, 1'b1, 1'b1, 7'h34)}
        };
        for (int k = 0; k < 8; k++) begin
            send(v[k].op, v[k].t, v[k].i, v[k].wr);
            total++;
            if (obs !== v[k].exp) begin
                bad++;
                $display("FAIL dirty_inval[%0d] got=%h exp=%h", k, obs, v[k].exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        vec_t v [5];
        v = '{
            '{OP_FILL,   7'h44, 6'd12, 1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_LOOKUP, 7'h44, 6'd12, 1'b1, rsp(1'b1, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_INVAL,  7'h44, 6'd12, 1'b0, rsp(1'b1, 3'd0, 1'b1, 1'b1, 7'h44)},
            '{OP_FILL,   7'h44, 6'd12, 1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_LOOKUP, 7'h44, 6'd12, 1'b0, rsp(1'b1, 3'd0, 1'b0, 1'b0, 7'h00)}
        };
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            bus.req_op = v[k].op;
            bus.req_addr = {v[k].t, v[k].i};
            bus.req_wr = v[k].wr;
            bus.req_valid = 1'b1;
            @(posedge clk);
            #1;
            total++;
            if (obs !== v[k].exp) begin
                bad++;
                $display("FAIL b2b[%0d] got=%h exp=%h", k, obs, v[k].exp);
            end
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (obs !== {1'b0, 1'b1, 12'h0}) begin
            bad++;
            $display("FAIL rsp_hold got=%h exp=%h", obs, {1'b0, 1'b1, 12'h0});
        end
    endtask

    task automatic test_flush;
        vec_t v [4];
        int n;
        int stray;
        @(negedge clk);
        bus.req_op = OP_LOOKUP;
        bus.req_addr = {7'h44, 6'd12};
        bus.req_wr = 1'b0;
        bus.req_valid = 1'b1;
        bus.flush_start = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.flush_start = 1'b0;
        total++;
        if (obs !== rsp(1'b1, 3'd0, 1'b0, 1'b0, 7'h00)) begin
            bad++;
            $display("FAIL flush_lookup got=%h exp=%h", obs, rsp(1'b1, 3'd0, 1'b0, 1'b0, 7'h00));
        end
        total++;
        if ({bus.req_ready, bus.flush_busy} !== 2'b01) begin
            bad++;
            $display("FAIL flush_enter got=%b exp=01", {bus.req_ready, bus.flush_busy});
        end
        n = 0;
        stray = 0;
        while (bus.flush_busy === 1'b1 && n < 200) begin
            n++;
            if (bus.req_ready !== 1'b0 || (n > 1 && bus.rsp_valid !== 1'b0)) stray++;
            bus.flush_start = n == 20;
            bus.req_valid = n == 20;
            @(posedge clk);
            #1;
        end
        bus.flush_start = 1'b0;
        bus.req_valid = 1'b0;
        total++;
        if (n !== 64) begin
            bad++;
            $display("FAIL flush_cycles got=%0d exp=64", n);
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("FAIL flush_quiet got=%0d exp=0", stray);
        end
        total++;
        if ({bus.req_ready, bus.flush_busy} !== 2'b10) begin
            bad++;
            $display("FAIL flush_exit got=%b exp=10", {bus.req_ready, bus.flush_busy});
        end
        v = '{
            '{OP_LOOKUP, 7'h44, 6'd12, 1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_LOOKUP, 7'h31, 6'd5,  1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_LOOKUP, 7'h32, 6'd5,  1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)},
            '{OP_LOOKUP, 7'h12, 6'd5,  1'b0, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)}
        };
        for (int k = 0; k < 4; k++) begin
            send(v[k].op, v[k].t, v[k].i, v[k].wr);
            total++;
            if (obs !== v[k].exp) begin
                bad++;
                $display("FAIL after_flush[%0d] got=%h exp=%h", k, obs, v[k].exp);
            end
        end
    endtask

    task automatic test_reset_midflush;
        send(OP_FILL, 7'h55, 6'd40, 1'b1);
        total++;
        if (obs !== rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)) begin
            bad++;
            $display("FAIL midflush_fill got=%h exp=%h", obs, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00));
        end
        @(negedge clk);
        bus.flush_start = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.flush_busy} !== 2'b00) begin
            bad++;
            $display("FAIL midflush_reset_hold got=%b exp=00", {bus.req_ready, bus.flush_busy});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.flush_busy, obs} !== {2'b10, 14'h0}) begin
            bad++;
            $display("FAIL midflush_release got=%h exp=%h", {bus.req_ready, bus.flush_busy, obs}, {2'b10, 14'h0});
        end
        send(OP_LOOKUP, 7'h55, 6'd40, 1'b0);
        total++;
        if (obs !== rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00)) begin
            bad++;
            $display("FAIL midflush_cleared got=%h exp=%h", obs, rsp(1'b0, 3'd0, 1'b0, 1'b0, 7'h00));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = OP_LOOKUP;
        bus.req_addr = '0;
        bus.req_wr = 1'b0;
        bus.flush_start = 1'b0;
        test_reset;
        test_lookup_empty;
        test_fill_set;
        test_evict;
        test_dirty_inval;
        test_back_to_back;
        test_flush;
        test_reset_midflush;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
